// File: rtl/vga_sync_pkg.sv
// Shared 640x480@60 Hz timing constants and the read-back register map for vga_sync_core.
package vga_sync_pkg;

   localparam int HD = 640;
   localparam int HF = 16;
   localparam int HB = 48;
   localparam int HR = 96;
   localparam int HT = HD + HF + HB + HR;

   localparam int VD = 480;
   localparam int VF = 10;
   localparam int VB = 33;
   localparam int VR = 2;
   localparam int VT = VD + VF + VB + VR;

   typedef enum logic [1:0] {
      REG_STATUS = 2'd0,
      REG_FRAME  = 2'd1,
      REG_POS    = 2'd2,
      REG_CLEAR  = 2'd3
   } reg_addr_e;

   // Bundle carried through the delay chain is {hsync, vsync, video_on}; idle = syncs high, blanked.
   localparam logic [2:0] SYNC_IDLE = 3'b110;

endpackage

// File: rtl/vga_sync_delay.sv
// Tick-enabled shift register that aligns {hsync, vsync, video_on} with the upstream pixel latency.
// DEPTH = 0 degenerates to a wire.
module vga_sync_delay
   import vga_sync_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en_i,
   input  logic [2:0] d_i,
   output logic [2:0] q_o
);

   if (DEPTH == 0) begin : g_bypass
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, reset, en_i};
      assign q_o = d_i;
   end else begin : g_chain
      logic [2:0] stage_q [DEPTH];

      // NOTE: the chain is plain flops, not a RAM, so every stage can take the async reset.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= SYNC_IDLE;
         end else if (en_i) begin
            // NOTE: non-blocking assignments let every stage sample its neighbour's old value.
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
         end
      end

      assign q_o = stage_q[DEPTH-1];
   end

endmodule

// File: rtl/vga_sync_core.sv
// VGA timing generator, pin driver and read-back registers at the end of the video stream chain.
// Define VGA_SYNC_FRAME_CNT_EN to build the frame counter, frame_start and the addr 1/3 registers.
module vga_sync_core
   import vga_sync_pkg::*;
#(
   parameter int CD         = 12,
   parameter int PIPE_DELAY = 2,
   parameter int TICK_DIV   = 4,
   // Timing overrides; left at their defaults for a real 640x480 panel.
   parameter int H_DISP     = HD,
   parameter int H_FRONT    = HF,
   parameter int H_BACK     = HB,
   parameter int H_RETR     = HR,
   parameter int V_DISP     = VD,
   parameter int V_FRONT    = VF,
   parameter int V_BACK     = VB,
   parameter int V_RETR     = VR
) (
   input  logic          clk,
   input  logic          reset,
   output logic [10:0]   x,
   output logic [10:0]   y,
   output logic          p_tick,
   output logic          frame_start,
   input  logic [CD-1:0] si_rgb,
   output logic [CD-1:0] rgb,
   output logic          hsync,
   output logic          vsync,
   input  logic          cs,
   input  logic          read,
   input  logic          write,
   input  logic [13:0]   addr,
   input  logic [31:0]   wr_data,
   output logic [31:0]   rd_data
);

   localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [10:0]      H_LAST   = 11'(H_DISP + H_FRONT + H_BACK + H_RETR - 1);
   localparam logic [10:0]      V_LAST   = 11'(V_DISP + V_FRONT + V_BACK + V_RETR - 1);
   localparam logic [10:0]      H_VIS    = 11'(H_DISP);
   localparam logic [10:0]      V_VIS    = 11'(V_DISP);
   localparam logic [10:0]      HS_FIRST = 11'(H_DISP + H_FRONT);
   localparam logic [10:0]      HS_LAST  = 11'(H_DISP + H_FRONT + H_RETR - 1);
   localparam logic [10:0]      VS_FIRST = 11'(V_DISP + V_FRONT);
   localparam logic [10:0]      VS_LAST  = 11'(V_DISP + V_FRONT + V_RETR - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic [10:0]      h_q, h_d, v_q, v_d;
   logic             h_end, v_end;
   logic             video_on_raw, hsync_raw, vsync_raw;
   logic [2:0]       sync_dly;
   logic [CD-1:0]    rgb_q;
   logic             hsync_q, vsync_q;
   logic [31:0]      frame_word, rd_word, rd_data_q;
   logic             unused_inputs;

   assign p_tick = (div_q == DIV_LAST);
   assign h_end  = (h_q == H_LAST);
   assign v_end  = (v_q == V_LAST);

   always_comb begin
      // NOTE: defaults first, so no path through this block can leave a variable unassigned (no latch).
      div_d = div_q + 1'b1;
      h_d   = h_q;
      v_d   = v_q;
      if (p_tick) begin
         div_d = '0;
         h_d   = h_end ? 11'd0 : h_q + 11'd1;
         if (h_end) v_d = v_end ? 11'd0 : v_q + 11'd1;
      end
   end

   assign video_on_raw = (h_q < H_VIS) && (v_q < V_VIS);
   assign hsync_raw    = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
   assign vsync_raw    = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));

   vga_sync_delay #(
      .DEPTH (PIPE_DELAY)
   ) u_delay (
      .clk   (clk),
      .reset (reset),
      .en_i  (p_tick),
      .d_i   ({hsync_raw, vsync_raw, video_on_raw}),
      .q_o   (sync_dly)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q     <= '0;
         h_q       <= '0;
         v_q       <= '0;
         rgb_q     <= '0;
         hsync_q   <= 1'b1;
         vsync_q   <= 1'b1;
         rd_data_q <= '0;
      end else begin
         div_q <= div_d;
         h_q   <= h_d;
         v_q   <= v_d;
         // Pins move only on pixel ticks so rgb and both syncs change on the same edge.
         if (p_tick) begin
            rgb_q   <= sync_dly[0] ? si_rgb : '0;
            hsync_q <= sync_dly[2];
            vsync_q <= sync_dly[1];
         end
         if (cs && read) rd_data_q <= rd_word;
      end
   end

`ifdef VGA_SYNC_FRAME_CNT_EN
   logic [31:0] frame_q, frame_d;
   logic        frame_wrap, frame_clear;

   assign frame_wrap  = p_tick && h_end && v_end;
   assign frame_clear = cs && write && (addr[1:0] == REG_CLEAR);

   // A clear landing on the wrap tick wins over the increment.
   always_comb begin
      frame_d = frame_q;
      if (frame_clear)     frame_d = '0;
      else if (frame_wrap) frame_d = frame_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) frame_q <= '0;
      else       frame_q <= frame_d;
   end

   assign frame_start = frame_wrap;
   assign frame_word  = frame_q;
`else
   assign frame_start = 1'b0;
   assign frame_word  = '0;
`endif

   always_comb begin
      rd_word = '0;
      case (reg_addr_e'(addr[1:0]))
         REG_STATUS: rd_word = {30'd0, video_on_raw, (v_q >= V_VIS)};
         REG_FRAME:  rd_word = frame_word;
         REG_POS:    rd_word = {10'd0, v_q, h_q};
         default:    rd_word = '0;
      endcase
   end

   // Write data carries no information and only addr[1:0] is decoded.
   assign unused_inputs = ^{wr_data, addr[13:2], write};

   assign x       = h_q;
   assign y       = v_q;
   assign rgb     = rgb_q;
   assign hsync   = hsync_q;
   assign vsync   = vsync_q;
   assign rd_data = rd_data_q;

endmodule

// File: tb/tb_vga_sync_core.sv
// Self-checking bench for vga_sync_core: random upstream pixels and bus traffic against a tick-index model.
// Horizontal timing is shrunk to 8 ticks per line so several full 525-line frames fit in a short run.
module tb_vga_sync_core;

   localparam int CD = 12;
   localparam int PD = 2;
   localparam int TD = 3;
   localparam int HD = 4;
   localparam int HF = 1;
   localparam int HB = 1;
   localparam int HR = 2;
   localparam int HT = HD + HF + HB + HR;
   localparam int VD = 480;
   localparam int VF = 10;
   localparam int VB = 33;
   localparam int VR = 2;
   localparam int VT = VD + VF + VB + VR;
   localparam int FT = HT * VT;
`ifdef VGA_SYNC_FRAME_CNT_EN
   localparam bit FCNT_EN = 1'b1;
`else
   localparam bit FCNT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [10:0]   x, y;
   logic          p_tick, frame_start;
   logic [CD-1:0] si_rgb = '0;
   logic [CD-1:0] rgb;
   logic          hsync, vsync;
   logic          cs = 1'b0, read = 1'b0, write = 1'b0;
   logic [13:0]   addr = '0;
   logic [31:0]   wr_data = '0;
   logic [31:0]   rd_data;

   int            checks = 0;
   int            errors = 0;
   int            k = 0;
   int            last_fs = -1;
   int            fs_seen = 0;
   int unsigned   frame_cnt_m = 0;
   logic [31:0]   exp_rd = '0;
   logic [CD-1:0] mask = '0;

   vga_sync_core #(
      .CD (CD), .PIPE_DELAY (PD), .TICK_DIV (TD),
      .H_DISP (HD), .H_FRONT (HF), .H_BACK (HB), .H_RETR (HR)
   ) dut (
      .clk (clk), .reset (reset), .x (x), .y (y), .p_tick (p_tick), .frame_start (frame_start),
      .si_rgb (si_rgb), .rgb (rgb), .hsync (hsync), .vsync (vsync),
      .cs (cs), .read (read), .write (write), .addr (addr), .wr_data (wr_data), .rd_data (rd_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, k);
      end
   endtask

   // Pixel index n since reset maps to a raster position with plain arithmetic.
   function automatic int h_of(input int n); return n % HT; endfunction
   function automatic int v_of(input int n); return (n / HT) % VT; endfunction
   function automatic bit vis(input int n); return (h_of(n) < HD) && (v_of(n) < VD); endfunction

   function automatic bit hs_pin(input int m);
      if (m < 0) return 1'b1;
      return !((h_of(m) >= HD + HF) && (h_of(m) < HD + HF + HR));
   endfunction

   function automatic bit vs_pin(input int m);
      if (m < 0) return 1'b1;
      return !((v_of(m) >= VD + VF) && (v_of(m) < VD + VF + VR));
   endfunction

   function automatic logic [CD-1:0] pix(input int n);
      logic [10:0] hh, vv;
      hh = 11'(h_of(n));
      vv = 11'(v_of(n));
      return {hh[3:0], vv[3:0], 4'hA} ^ mask;
   endfunction

   function automatic logic [31:0] model_word(input logic [1:0] a, input int n);
      case (a)
         2'd0:    return {30'd0, vis(n), (v_of(n) >= VD)};
         2'd1:    return FCNT_EN ? frame_cnt_m : 32'd0;
         2'd2:    return {10'd0, 11'(v_of(n)), 11'(h_of(n))};
         default: return 32'd0;
      endcase
   endfunction

   // Upstream model presents pixel n-PD while the counter shows n; random bus traffic besides.
   task automatic drive_cycle();
      int n;
      n       = k / TD;
      si_rgb  = (n - PD >= 0) ? pix(n - PD) : CD'($urandom);
      cs      = ($urandom_range(0, 3) == 0);
      read    = ($urandom_range(0, 3) == 0);
      write   = ($urandom_range(0, 5) == 0);
      addr    = 14'($urandom);
      wr_data = $urandom;
      if (cs && write && addr[1:0] == 2'd3) addr[1:0] = 2'd2;
   endtask

   task automatic check_cycle();
      int n, m;
      bit pt;
      n  = k / TD;
      m  = n - 1 - PD;
      pt = (k % TD) == TD - 1;
      check("x", 32'(x), 32'(h_of(n)));
      check("y", 32'(y), 32'(v_of(n)));
      check("p_tick", 32'(p_tick), 32'(pt));
      check("frame_start", 32'(frame_start), 32'(FCNT_EN && pt && (n % FT) == FT - 1));
      check("hsync", 32'(hsync), 32'(hs_pin(m)));
      check("vsync", 32'(vsync), 32'(vs_pin(m)));
      check("rgb", 32'(rgb), 32'((m >= 0 && vis(m)) ? pix(m) : '0));
      check("rd_data", rd_data, exp_rd);
      if (frame_start === 1'b1) begin
         fs_seen++;
         if (last_fs >= 0) check("frame_period", 32'(k - last_fs), 32'(FT * TD));
         last_fs = k;
      end
   endtask

   task automatic advance();
      int n;
      bit pt;
      n  = k / TD;
      pt = (k % TD) == TD - 1;
      if (cs && read) exp_rd = model_word(addr[1:0], n);
      if (FCNT_EN) begin
         if (cs && write && addr[1:0] == 2'd3) frame_cnt_m = 0;
         else if (pt && (n % FT) == FT - 1)    frame_cnt_m++;
      end
      @(posedge clk);
      #1;
      k++;
      drive_cycle();
      check_cycle();
   endtask

   task automatic run_until(input int target);
      while (k < target) advance();
   endtask

   task automatic apply_reset();
      cs    = 1'b0;
      read  = 1'b0;
      write = 1'b0;
      reset = 1'b1;
      #1;
      check("rst_x", 32'(x), 32'd0);
      check("rst_y", 32'(y), 32'd0);
      check("rst_hsync", 32'(hsync), 32'd1);
      check("rst_vsync", 32'(vsync), 32'd1);
      check("rst_rgb", 32'(rgb), 32'd0);
      check("rst_rd_data", rd_data, 32'd0);
      check("rst_frame_start", 32'(frame_start), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      reset       = 1'b0;
      k           = 0;
      frame_cnt_m = 0;
      exp_rd      = '0;
      last_fs     = -1;
      fs_seen     = 0;
      drive_cycle();
      check_cycle();
   endtask

   initial begin
      mask = CD'($urandom);
      apply_reset();

      // Position read-back at h=5, v=7.
      run_until((7 * HT + 5) * TD);
      cs = 1'b1; read = 1'b1; write = 1'b0; addr = {12'($urandom), 2'd2};
      advance();
      check("rd_pos_h5_v7", rd_data, 32'h0000_3805);

      // Reset mid-frame inside the visible area, then count from (0,0) again.
      run_until((200 * HT + 3) * TD + 1);
      apply_reset();

      // Status read during vertical blanking.
      run_until((500 * HT + 2) * TD);
      cs = 1'b1; read = 1'b1; write = 1'b0; addr = {12'($urandom), 2'd0};
      advance();
      check("rd_status_vblank", rd_data, 32'h0000_0001);

      // Frame counter after three complete frames.
      run_until(3 * FT * TD);
      cs = 1'b1; read = 1'b1; write = 1'b0; addr = {12'($urandom), 2'd1};
      advance();
      check("rd_frames_3", rd_data, FCNT_EN ? 32'd3 : 32'd0);

      // Clear written on the wrap tick beats the increment.
      run_until(4 * FT * TD - 1);
      cs = 1'b1; read = 1'b0; write = 1'b1; addr = {12'($urandom), 2'd3};
      advance();
      cs = 1'b1; read = 1'b1; write = 1'b0; addr = {12'($urandom), 2'd1};
      advance();
      check("rd_frames_after_clear", rd_data, 32'd0);
      check("frame_start_count", 32'(fs_seen), FCNT_EN ? 32'd4 : 32'd0);

      repeat (20) advance();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_sync_core.md
# vga_sync_core

Sink end of the video stream chain: generates the 640x480@60 Hz frame counter (`x`, `y`) that every upstream video core consumes. Receives the final blended pixel stream back (`si_rgb`) and drives the VGA pins. Aligns `hsync`/`vsync` and blanking with the upstream pipeline latency. Exposes a read-back register set (status, frame count, scan position) on the video slot interface so the processor can poll vertical blanking before updating sprite registers.

## Interface
- CD, 12, color depth of stream and output
- PIPE_DELAY, 2, upstream stream latency in pixel ticks from `x`/`y` to valid `si_rgb`; range 0..7
- TICK_DIV, 4, clk cycles per pixel (100 MHz clk -> 25 MHz pixel)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- x  out  11  current horizontal count
- y  out  11  current vertical count
- p_tick  out  1  one-clk pixel strobe
- frame_start  out  1  one-clk pulse at frame wrap
- si_rgb  in  CD  final stream pixel from upstream chain
- rgb  out  CD  VGA color, forced 0 in blanking
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- cs  in  1  slot select
- read  in  1  read strobe
- write  in  1  write strobe
- addr  in  14  slot word address; only addr[1:0] decoded
- wr_data  in  32  write data (ignored; any write to addr 3 clears)
- rd_data  out  32  registered read data

## Operation
- Divider `div` counts 0..TICK_DIV-1 and wraps; `p_tick` = (div==TICK_DIV-1).
- h counter 0..799, advances on `p_tick`; v counter 0..524, advances on `p_tick` when h==799. `x`=h, `y`=v.
- Raw timing: video_on = h<640 && v<480; hsync_raw low for h in 656..751; vsync_raw low for v in 490..491.
- hsync_raw, vsync_raw and video_on pass through a PIPE_DELAY-stage shift register advanced only on `p_tick`.
- Output register, loaded on `p_tick`: rgb = delayed video_on ? si_rgb : 0; hsync/vsync = delayed values.
- Frame counter (32-bit) increments and `frame_start` pulses on `p_tick` with h==799, v==524. Wraps at 2^32-1 -> 0.
- Register map (addr[1:0]):
  - 0: status — bit0 = v>=480 (vblank), bit1 = video_on, rest 0.
  - 1: frame counter.
  - 2: {10'b0, y, x}.
  - 3: reads 0; a write clears the frame counter.
- Read: on cs&read, rd_data loads the selected word next clk; otherwise it holds.
- Simultaneous clear and increment: clear wins (counter = 0).

## Timing
- Reset values: div, h, v = 0; frame counter 0; hsync, vsync = 1; rgb = 0; rd_data = 0; delay chain filled with sync = 1, video_on = 0.
- Reset mid-frame restarts at (0,0) immediately; first visible pixel emerges PIPE_DELAY+1 p_ticks after the (0,0) tick.
- Pin latency relative to the h/v count: PIPE_DELAY+1 pixel ticks; rgb and syncs update on the same clk edge.
- `x`/`y` change one clk after `p_tick`, and are stable for TICK_DIV clks.
- PIPE_DELAY=0: delay chain is bypassed; only the output register remains.
- rd_data latency: 1 clk.

## Configuration
- `VGA_SYNC_FRAME_CNT_EN` defined: frame counter, `frame_start`, addr 1 readback and the addr 3 clear are present.
- Undefined: no counter flops; `frame_start` is tied 0; addr 1 reads 0; writes are ignored. Sync and rgb behaviour is unchanged.

## Structure
- `vga_sync_pkg`: timing constants (HD=640, HF=16, HB=48, HR=96, VD=480, VF=10, VB=33, VR=2, derived totals), register address localparams.
- Sub-module `vga_sync_delay`: parameterized-depth, tick-enabled shift register carrying {hsync, vsync, video_on}, with reset to inactive values.

## Test plan
- Reset, run 2 frames with TICK_DIV=4 -> exactly 800*525*4 clks between `frame_start` pulses; hsync low for 96 ticks per line, vsync low for 2 lines (v 490..491, offset by PIPE_DELAY+1 ticks).
- si_rgb = {x[3:0],y[3:0],4'hA}, PIPE_DELAY=2 -> the rgb at pin tick n equals the stimulus computed for count n-3; rgb = 0 for every h>=640 or v>=480.
- Assert reset at h=300, v=200 -> hsync=vsync=1, rgb=0 at once; after release, counting resumes from 0,0 with no sync glitch.
- Read addr 0 during v=500 -> rd_data bit0=1 one clk later; read addr 2 at h=5, v=7 -> 0x0000_3805.
- With the macro defined: after 3 frames addr 1 reads 3; write addr 3 on the wrap tick -> the counter reads 0, not 1.
- Without the macro: addr 1 reads 0 and `frame_start` stays 0 across 2 frames.
